write_ptr_full_ctrl: RTL and testbench

WRITE_PTR_FULL_CTRL -- requirements
Module: write_ptr_full_ctrl

---
 rtl/write_ptr_full_ctrl.sv | 80 ++++++++
 tb/tb_write_ptr_full_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/write_ptr_full_ctrl.sv
// Write-side pointer and flag control for an asynchronous FIFO.
// It keeps a binary and Gray write pointer and derives full, almost-full, level and overflow.
module write_ptr_full_ctrl #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned AF_MARGIN  = 4
) (
  input  logic                  w_clk,
  input  logic                  rst,
  input  logic                  w_inc,
  input  logic [ADDR_WIDTH:0]   r_ptr_gray,
  input  logic                  ovf_clr,
  output logic                  Write_EN,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [ADDR_WIDTH:0]   w_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  overflow
);

  localparam int unsigned PW       = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

  logic [PW-1:0] rq1, rq2;
  logic [PW-1:0] w_bin;
  logic [PW-1:0] w_bin_next, w_gray_next, r_bin_sync, level_next;
  logic          full_next, almost_full_next;

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Push is gated by the registered full flag and by reset.
  assign Write_EN   = w_inc & ~full & ~rst;
  assign write_addr = w_bin[ADDR_WIDTH-1:0];

  always_comb begin
    w_bin_next       = w_bin + PW'(Write_EN);
    w_gray_next      = (w_bin_next >> 1) ^ w_bin_next;
    r_bin_sync       = gray2bin(rq2);
    level_next       = w_bin_next - r_bin_sync;
    // Full when the write pointer is exactly one lap ahead of the synchronized read pointer.
    full_next        = (w_gray_next == {~rq2[PW-1:PW-2], rq2[PW-3:0]});
    almost_full_next = (level_next >= PW'(AF_LEVEL));
  end

  always_ff @(posedge w_clk) begin
    if (rst) begin
      rq1         <= '0;
      rq2         <= '0;
      w_bin       <= '0;
      w_ptr_gray  <= '0;
      w_level     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      rq1         <= r_ptr_gray;
      rq2         <= rq1;
      w_bin       <= w_bin_next;
      w_ptr_gray  <= w_gray_next;
      w_level     <= level_next;
      full        <= full_next;
      almost_full <= almost_full_next;
      // A new overflow event wins over a simultaneous clear.
      if (w_inc && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_write_ptr_full_ctrl.sv
// Directed bench for write_ptr_full_ctrl with a count-based reference model and expectation queue.
module tb_write_ptr_full_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned PW = 6;

  logic          w_clk = 1'b0;
  logic          rst, w_inc, ovf_clr;
  logic [PW-1:0] r_ptr_gray;
  logic          Write_EN, full, almost_full, overflow;
  logic [AW-1:0] write_addr;
  logic [PW-1:0] w_ptr_gray, w_level;

  always #5 w_clk = ~w_clk;

  write_ptr_full_ctrl #(.ADDR_WIDTH(AW), .AF_MARGIN(4)) dut (
    .w_clk(w_clk), .rst(rst), .w_inc(w_inc), .r_ptr_gray(r_ptr_gray), .ovf_clr(ovf_clr),
    .Write_EN(Write_EN), .write_addr(write_addr), .w_ptr_gray(w_ptr_gray), .full(full),
    .almost_full(almost_full), .w_level(w_level), .overflow(overflow)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] gray;
    logic          full;
    logic          af;
    logic          ovf;
    logic [PW-1:0] level;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  // Reference state: write count and the read pointer as seen two edges late.
  int m_wbin = 0, m_rq1 = 0, m_rq2 = 0;
  bit m_full = 0, m_ovf = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_level();
    return (m_wbin - m_rq2 + 64) % 64;
  endfunction

  task automatic step(input bit r, input bit inc, input bit clr, input int rb);
    exp_t e;
    int   nb, lvl;
    bit   we;
    rst        = r;
    w_inc      = inc;
    ovf_clr    = clr;
    r_ptr_gray = PW'(rb ^ (rb >> 1));
    #1;
    we = !r && inc && !m_full;
    check("write_en", 32'(Write_EN), 32'(we));
    if (r) begin
      m_wbin = 0; m_rq1 = 0; m_rq2 = 0; m_full = 0; m_ovf = 0; lvl = 0;
    end else begin
      nb     = (m_wbin + int'(we)) % 64;
      lvl    = (nb - m_rq2 + 64) % 64;
      m_ovf  = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_full = (lvl == 32);
      m_rq2  = m_rq1;
      m_rq1  = rb;
      m_wbin = nb;
    end
    e.addr  = AW'(m_wbin % 32);
    e.gray  = PW'(m_wbin ^ (m_wbin >> 1));
    e.full  = m_full;
    e.af    = (lvl >= 28);
    e.ovf   = m_ovf;
    e.level = PW'(lvl);
    sb.push_back(e);
    @(posedge w_clk);
    #1;
    e = sb.pop_front();
    check("write_addr", 32'(write_addr), 32'(e.addr));
    check("w_ptr_gray", 32'(w_ptr_gray), 32'(e.gray));
    check("full", 32'(full), 32'(e.full));
    check("almost_full", 32'(almost_full), 32'(e.af));
    check("overflow", 32'(overflow), 32'(e.ovf));
    check("w_level", 32'(w_level), 32'(e.level));
  endtask

  initial begin
    int hist[$];
    int rb;
    int guard;
    rst = 1'b1; w_inc = 1'b0; ovf_clr = 1'b0; r_ptr_gray = '0;

    // Reset with a push request present, then idle.
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);

    // Fill from empty with the reader parked at zero.
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 0, 0);
      if (i == 26) check("af_before_28", 32'(almost_full), 32'(0));
      if (i == 27) check("af_at_28", 32'(almost_full), 32'(1));
    end
    check("gray_at_full", 32'(w_ptr_gray), 32'(6'b110000));
    check("full_after_32", 32'(full), 32'(1));

    // Overflow, clear, and clear colliding with a new overflow.
    step(0, 1, 0, 0);
    check("ovf_set", 32'(overflow), 32'(1));
    check("addr_held", 32'(write_addr), 32'(0));
    step(0, 0, 1, 0);
    check("ovf_cleared", 32'(overflow), 32'(0));
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    check("ovf_clr_collide", 32'(overflow), 32'(1));
    step(0, 0, 1, 0);

    // One read: full must hold through the synchronizer latency.
    step(0, 0, 0, 1);
    check("full_hold_1", 32'(full), 32'(1));
    step(0, 0, 0, 1);
    check("full_hold_2", 32'(full), 32'(1));
    step(0, 0, 0, 1);
    check("full_released", 32'(full), 32'(0));
    check("level_31", 32'(w_level), 32'(31));

    // Wrap the pointer with a reader trailing a few cycles behind.
    step(1, 0, 0, 0);
    rb = 0;
    for (int i = 0; i < 70; i++) begin
      hist.push_back(m_wbin);
      if (hist.size() > 4) rb = hist.pop_front();
      step(0, 1, 0, rb);
      check("no_spurious_full", 32'(full), 32'(0));
      check("level_le_depth", 32'(w_level <= 6'd32), 32'(1));
    end
    check("wrapped_addr", 32'(write_addr), 32'(6));

    // Build up to level 20 against a parked reader, then reset mid-push.
    guard = 0;
    while (model_level() < 20 && guard < 40) begin
      step(0, 1, 0, rb);
      guard++;
    end
    check("level_20", 32'(w_level), 32'(20));
    step(1, 1, 0, 0);
    check("reset_level", 32'(w_level), 32'(0));
    check("reset_addr", 32'(write_addr), 32'(0));
    step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
